// File: rtl/rf_write_arbiter.sv
// Two-port register-file write arbiter: each writeback port owns a one-entry
// buffer, and a round-robin grant drains one buffer per cycle into the RF write port.
module rf_write_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid_i,
  input  logic [4:0]   req0_addr_i,
  input  logic [N-1:0] req0_data_i,
  output logic         req0_ready_o,
  input  logic         req1_valid_i,
  input  logic [4:0]   req1_addr_i,
  input  logic [N-1:0] req1_data_i,
  output logic         req1_ready_o,
  output logic         Reg_Write_o,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o,
  output logic [31:0]  busy_mask_o
);

  // Handshake: a request transfers on a rising edge where valid_i && ready_o.
  // ready_o never depends on valid_i; it is high when the buffer is empty or
  // is being drained this cycle, so a granted buffer can refill on the same edge.

  logic         v0_q, v0_d, v1_q, v1_d;
  logic [4:0]   a0_q, a0_d, a1_q, a1_d;
  logic [N-1:0] d0_q, d0_d, d1_q, d1_d;
  logic         last_q, last_d;  // 1: port 1 was granted last
  logic         reg_write_q, reg_write_d;
  logic [4:0]   wr_reg_q, wr_reg_d;
  logic [N-1:0] wr_data_q, wr_data_d;
  logic [31:0]  busy_q, busy_d;

  logic         gnt0, gnt1, any_gnt, hs0, hs1;
  logic [4:0]   g_addr;
  logic [N-1:0] g_data;

  always_comb begin
    gnt0    = v0_q & (~v1_q | last_q);
    gnt1    = v1_q & (~v0_q | ~last_q);
    any_gnt = gnt0 | gnt1;

    req0_ready_o = reset & (~v0_q | gnt0);
    req1_ready_o = reset & (~v1_q | gnt1);
    hs0 = req0_valid_i & req0_ready_o;
    hs1 = req1_valid_i & req1_ready_o;

    v0_d = hs0 | (v0_q & ~gnt0);
    v1_d = hs1 | (v1_q & ~gnt1);
    a0_d = hs0 ? req0_addr_i : a0_q;
    d0_d = hs0 ? req0_data_i : d0_q;
    a1_d = hs1 ? req1_addr_i : a1_q;
    d1_d = hs1 ? req1_data_i : d1_q;

    last_d = last_q;
    if (gnt1)      last_d = 1'b1;
    else if (gnt0) last_d = 1'b0;

    g_addr = gnt1 ? a1_q : a0_q;
    g_data = gnt1 ? d1_q : d0_q;

    // Writes to r0 are consumed but never enabled.
    reg_write_d = any_gnt & (g_addr != 5'd0);
    wr_reg_d    = any_gnt ? g_addr : wr_reg_q;
    wr_data_d   = any_gnt ? g_data : wr_data_q;

    busy_d = '0;
    if (v0_d) busy_d[a0_d] = 1'b1;
    if (v1_d) busy_d[a1_d] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      a0_q        <= '0;
      a1_q        <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      last_q      <= 1'b1;
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      last_q      <= last_d;
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign Reg_Write_o      = reg_write_q;
  assign Write_Register_o = wr_reg_q;
  assign Write_Data_o     = wr_data_q;
  assign busy_mask_o      = busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: single-port, contention, streaming,
// r0 suppression, same-register ordering and mid-operation reset.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid_i, req1_valid_i;
  logic [4:0]  req0_addr_i, req1_addr_i;
  logic [31:0] req0_data_i, req1_data_i;
  logic        req0_ready_o, req1_ready_o;
  logic        Reg_Write_o;
  logic [4:0]  Write_Register_o;
  logic [31:0] Write_Data_o;
  logic [31:0] busy_mask_o;

  int n_assert = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];  // {addr, data} in expected grant order

  rf_write_arbiter #(.N(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i),
    .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i),
    .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
    .Reg_Write_o(Reg_Write_o), .Write_Register_o(Write_Register_o),
    .Write_Data_o(Write_Data_o), .busy_mask_o(busy_mask_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_addr_i = '0; req1_addr_i = '0;
    req0_data_i = '0; req1_data_i = '0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #6 reset = 1'b1;
    step();
  endtask

  initial begin
    int i0, i1;
    logic [36:0] e;
    idle_inputs();
    reset = 1'b0;
    #3;
    check("rst_ready0", {31'b0, req0_ready_o}, 32'd0);
    check("rst_ready1", {31'b0, req1_ready_o}, 32'd0);
    check("rst_rw", {31'b0, Reg_Write_o}, 32'd0);
    check("rst_busy", busy_mask_o, 32'd0);
    check("rst_wd", Write_Data_o, 32'd0);
    #10 reset = 1'b1;
    step();
    check("post_rst_ready0", {31'b0, req0_ready_o}, 32'd1);
    check("post_rst_ready1", {31'b0, req1_ready_o}, 32'd1);

    // Port 0 alone: addr 5, data AA
    req0_valid_i = 1'b1; req0_addr_i = 5'd5; req0_data_i = 32'h0000_00AA;
    step();  // E0
    idle_inputs();
    check("p0_busy_e0", busy_mask_o, 32'h0000_0020);
    check("p0_rw_e0", {31'b0, Reg_Write_o}, 32'd0);
    step();  // E1
    check("p0_rw_e1", {31'b0, Reg_Write_o}, 32'd1);
    check("p0_wr_e1", {27'b0, Write_Register_o}, 32'd5);
    check("p0_wd_e1", Write_Data_o, 32'h0000_00AA);
    check("p0_busy_e1", busy_mask_o, 32'd0);
    step();  // E2
    check("p0_rw_e2", {31'b0, Reg_Write_o}, 32'd0);
    check("p0_wr_hold", {27'b0, Write_Register_o}, 32'd5);
    check("p0_wd_hold", Write_Data_o, 32'h0000_00AA);

    // Port 1 alone: addr 12, data 5A5A
    req1_valid_i = 1'b1; req1_addr_i = 5'd12; req1_data_i = 32'h0000_5A5A;
    step();
    idle_inputs();
    step();
    check("p1_rw", {31'b0, Reg_Write_o}, 32'd1);
    check("p1_wr", {27'b0, Write_Register_o}, 32'd12);
    check("p1_wd", Write_Data_o, 32'h0000_5A5A);

    // Contention after reset: port 0 wins first
    do_reset();
    req0_valid_i = 1'b1; req0_addr_i = 5'd3; req0_data_i = 32'h11;
    req1_valid_i = 1'b1; req1_addr_i = 5'd4; req1_data_i = 32'h22;
    step();  // E0
    idle_inputs();
    check("ct_busy_e0", busy_mask_o, 32'h0000_0018);
    step();  // E1
    check("ct_rw_e1", {31'b0, Reg_Write_o}, 32'd1);
    check("ct_wr_e1", {27'b0, Write_Register_o}, 32'd3);
    check("ct_wd_e1", Write_Data_o, 32'h11);
    check("ct_busy_e1", busy_mask_o, 32'h0000_0010);
    step();  // E2
    check("ct_rw_e2", {31'b0, Reg_Write_o}, 32'd1);
    check("ct_wr_e2", {27'b0, Write_Register_o}, 32'd4);
    check("ct_wd_e2", Write_Data_o, 32'h22);
    check("ct_busy_e2", busy_mask_o, 32'd0);
    // Port 1 was last, so port 0 wins the next contention
    req0_valid_i = 1'b1; req0_addr_i = 5'd9;  req0_data_i = 32'h33;
    req1_valid_i = 1'b1; req1_addr_i = 5'd10; req1_data_i = 32'h44;
    step();
    idle_inputs();
    step();
    check("ct2_wr_first", {27'b0, Write_Register_o}, 32'd9);
    step();
    check("ct2_wr_second", {27'b0, Write_Register_o}, 32'd10);

    // Streaming: both ports valid for 8 cycles
    do_reset();
    for (int j = 0; j < 5; j++) begin
      exp_q.push_back({5'(8 + j), 32'h100 + 32'(j)});
      if (j < 4) exp_q.push_back({5'(16 + j), 32'h200 + 32'(j)});
    end
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      req0_valid_i = 1'b1; req0_addr_i = 5'(8 + i0);  req0_data_i = 32'h100 + 32'(i0);
      req1_valid_i = 1'b1; req1_addr_i = 5'(16 + i1); req1_data_i = 32'h200 + 32'(i1);
      #1;
      if (k >= 1) begin
        check("st_ready0", {31'b0, req0_ready_o}, {31'b0, k[0]});
        check("st_ready1", {31'b0, req1_ready_o}, {31'b0, ~k[0]});
      end
      if (k >= 2) begin
        e = exp_q.pop_front();
        check("st_rw", {31'b0, Reg_Write_o}, 32'd1);
        check("st_wr", {27'b0, Write_Register_o}, {27'b0, e[36:32]});
        check("st_wd", Write_Data_o, e[31:0]);
      end
      if (req0_ready_o) i0++;
      if (req1_ready_o) i1++;
      step();
    end
    idle_inputs();
    for (int j = 0; j < 3; j++) begin
      e = exp_q.pop_front();
      check("st_rw_tail", {31'b0, Reg_Write_o}, 32'd1);
      check("st_wr_tail", {27'b0, Write_Register_o}, {27'b0, e[36:32]});
      check("st_wd_tail", Write_Data_o, e[31:0]);
      step();
    end
    check("st_drained_rw", {31'b0, Reg_Write_o}, 32'd0);
    check("st_queue_empty", 32'(exp_q.size()), 32'd0);

    // Write to r0 is consumed silently
    req0_valid_i = 1'b1; req0_addr_i = 5'd0; req0_data_i = 32'hFFFF_FFFF;
    #1;
    check("r0_ready", {31'b0, req0_ready_o}, 32'd1);
    step();
    idle_inputs();
    check("r0_busy_e0", busy_mask_o, 32'd0);
    check("r0_rw_e0", {31'b0, Reg_Write_o}, 32'd0);
    step();
    check("r0_rw_e1", {31'b0, Reg_Write_o}, 32'd0);
    check("r0_busy_e1", busy_mask_o, 32'd0);
    check("r0_ready_after", {31'b0, req0_ready_o}, 32'd1);

    // Both ports hit r7: p0 then p1, final value 2
    do_reset();
    req0_valid_i = 1'b1; req0_addr_i = 5'd7; req0_data_i = 32'h1;
    req1_valid_i = 1'b1; req1_addr_i = 5'd7; req1_data_i = 32'h2;
    step();
    idle_inputs();
    check("r7_busy_e0", busy_mask_o, 32'h0000_0080);
    step();
    check("r7_rw_e1", {31'b0, Reg_Write_o}, 32'd1);
    check("r7_wd_e1", Write_Data_o, 32'h1);
    check("r7_busy_e1", busy_mask_o, 32'h0000_0080);
    step();
    check("r7_rw_e2", {31'b0, Reg_Write_o}, 32'd1);
    check("r7_wr_e2", {27'b0, Write_Register_o}, 32'd7);
    check("r7_wd_e2", Write_Data_o, 32'h2);
    check("r7_busy_e2", busy_mask_o, 32'd0);

    // Reset while both buffers are full
    req0_valid_i = 1'b1; req0_addr_i = 5'd20; req0_data_i = 32'hAB;
    req1_valid_i = 1'b1; req1_addr_i = 5'd21; req1_data_i = 32'hCD;
    step();
    idle_inputs();
    check("mr_busy_full", busy_mask_o, 32'h0030_0000);
    #1 reset = 1'b0;
    #1;
    check("mr_rw", {31'b0, Reg_Write_o}, 32'd0);
    check("mr_busy", busy_mask_o, 32'd0);
    check("mr_wd", Write_Data_o, 32'd0);
    check("mr_wr", {27'b0, Write_Register_o}, 32'd0);
    check("mr_ready0", {31'b0, req0_ready_o}, 32'd0);
    #4 reset = 1'b1;
    step();
    check("mr_rw_after1", {31'b0, Reg_Write_o}, 32'd0);
    step();
    check("mr_rw_after2", {31'b0, Reg_Write_o}, 32'd0);
    check("mr_busy_after", busy_mask_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
